// File: rtl/mod_exp_seq_if.sv
// Request/response bundle for the sequential modular exponentiator.
// The master drives the operands and start; the slave returns result and status.
interface mod_exp_seq_if #(
  parameter int WIDTH     = 16,
  parameter int EXP_WIDTH = 16
);
  logic                 start;
  logic [WIDTH-1:0]     m;
  logic [EXP_WIDTH-1:0] e;
  logic [WIDTH-1:0]     n;
  logic [WIDTH-1:0]     result;
  logic                 valid;
  logic                 busy;
  logic                 error;

  modport master (
    output start, m, e, n,
    input  result, valid, busy, error
  );

  modport slave (
    input  start, m, e, n,
    output result, valid, busy, error
  );
endinterface

// File: rtl/mod_exp_seq.sv
// Sequential modular exponentiator: result = m^e mod n.
// Left-to-right square-and-multiply over e. Every modular product is built
// bit-serially (one multiplier bit per clock), so WIDTH cycles per product
// and no wide multiplier or divider is needed.
module mod_exp_seq #(
  parameter int WIDTH     = 16,
  parameter int EXP_WIDTH = 16
) (
  input  logic         clk,
  input  logic         reset,
  mod_exp_seq_if.slave bus
);

  localparam int CW = (WIDTH > 1)     ? $clog2(WIDTH)     : 1;
  localparam int IW = (EXP_WIDTH > 1) ? $clog2(EXP_WIDTH) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_REDUCE,
    S_SCAN,
    S_SQUARE,
    S_MULT,
    S_DONE
  } state_t;

  state_t               r_state;
  logic [WIDTH-1:0]     r_n;       // latched modulus
  logic [EXP_WIDTH-1:0] r_e;       // exponent, shifted so the bit in work sits at the MSB
  logic [IW-1:0]        r_idx;     // index of the exponent bit at r_e's MSB
  logic [CW-1:0]        r_cnt;     // remaining multiplier bits of the running product
  logic [WIDTH-1:0]     r_mm;      // partial product of the running modmul, always < n
  logic [WIDTH-1:0]     r_a;       // modmul addend operand, always < n
  logic [WIDTH-1:0]     r_b;       // modmul multiplier, consumed MSB first
  logic [WIDTH-1:0]     r_mb;      // base reduced mod n
  logic [WIDTH-1:0]     r_result;
  logic                 r_valid;
  logic                 r_busy;
  logic                 r_error;

  // One extra bit holds 2*acc and acc+a without wrap, even for n = 2^WIDTH-1.
  logic [WIDTH:0]       w_n_ext;
  logic [WIDTH:0]       w_dbl;
  logic [WIDTH:0]       w_dbl_red;
  logic [WIDTH:0]       w_sum;
  logic [WIDTH-1:0]     w_prod;

  // One interleaved modmul step: double, reduce, conditionally add a, reduce.
  always_comb begin
    w_n_ext   = {1'b0, r_n};
    w_dbl     = {r_mm, 1'b0};
    w_dbl_red = (w_dbl >= w_n_ext) ? (w_dbl - w_n_ext) : w_dbl;
    w_sum     = r_b[WIDTH-1] ? (w_dbl_red + {1'b0, r_a}) : w_dbl_red;
    w_prod    = WIDTH'((w_sum >= w_n_ext) ? (w_sum - w_n_ext) : w_sum);
  end

  // Control FSM and datapath; w_prod is the finished product on the cycle r_cnt hits 0.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_result <= '0;
      r_valid  <= 1'b0;
      r_busy   <= 1'b0;
      r_error  <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_n    <= bus.n;
            r_e    <= bus.e;
            r_idx  <= IW'(EXP_WIDTH - 1);
            r_busy <= 1'b1;
            if (bus.n < WIDTH'(2)) begin
              // Degenerate modulus: report at once, no arithmetic.
              r_state  <= S_DONE;
              r_result <= '0;
              r_error  <= 1'b1;
              r_valid  <= 1'b1;
            end else begin
              // m mod n computed as modmul(1, m); handles any m, including m >= n.
              r_state <= S_REDUCE;
              r_mm    <= '0;
              r_a     <= WIDTH'(1);
              r_b     <= bus.m;
              r_cnt   <= CW'(WIDTH - 1);
            end
          end
        end

        S_REDUCE: begin
          r_mm  <= w_prod;
          r_b   <= r_b << 1;
          r_cnt <= r_cnt - 1'b1;
          if (r_cnt == '0) begin
            r_mb    <= w_prod;
            r_state <= S_SCAN;
          end
        end

        S_SCAN: begin
          // Skip leading zeros; the first 1 seeds the accumulator with mb.
          if (r_e[EXP_WIDTH-1]) begin
            if (r_idx == '0) begin
              r_state  <= S_DONE;
              r_result <= r_mb;
              r_error  <= 1'b0;
              r_valid  <= 1'b1;
            end else begin
              r_state <= S_SQUARE;
              r_mm    <= '0;
              r_a     <= r_mb;
              r_b     <= r_mb;
              r_cnt   <= CW'(WIDTH - 1);
              r_e     <= r_e << 1;
              r_idx   <= r_idx - 1'b1;
            end
          end else if (r_idx == '0) begin
            // e == 0: x^0 = 1 for every x, including x = 0.
            r_state  <= S_DONE;
            r_result <= WIDTH'(1);
            r_error  <= 1'b0;
            r_valid  <= 1'b1;
          end else begin
            r_e   <= r_e << 1;
            r_idx <= r_idx - 1'b1;
          end
        end

        S_SQUARE: begin
          r_mm  <= w_prod;
          r_b   <= r_b << 1;
          r_cnt <= r_cnt - 1'b1;
          if (r_cnt == '0) begin
            if (r_e[EXP_WIDTH-1]) begin
              r_state <= S_MULT;
              r_mm    <= '0;
              r_a     <= w_prod;
              r_b     <= r_mb;
              r_cnt   <= CW'(WIDTH - 1);
            end else if (r_idx == '0) begin
              r_state  <= S_DONE;
              r_result <= w_prod;
              r_error  <= 1'b0;
              r_valid  <= 1'b1;
            end else begin
              r_mm  <= '0;
              r_a   <= w_prod;
              r_b   <= w_prod;
              r_cnt <= CW'(WIDTH - 1);
              r_e   <= r_e << 1;
              r_idx <= r_idx - 1'b1;
            end
          end
        end

        S_MULT: begin
          r_mm  <= w_prod;
          r_b   <= r_b << 1;
          r_cnt <= r_cnt - 1'b1;
          if (r_cnt == '0) begin
            if (r_idx == '0) begin
              r_state  <= S_DONE;
              r_result <= w_prod;
              r_error  <= 1'b0;
              r_valid  <= 1'b1;
            end else begin
              r_state <= S_SQUARE;
              r_mm    <= '0;
              r_a     <= w_prod;
              r_b     <= w_prod;
              r_cnt   <= CW'(WIDTH - 1);
              r_e     <= r_e << 1;
              r_idx   <= r_idx - 1'b1;
            end
          end
        end

        S_DONE: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end

        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.result = r_result;
  assign bus.valid  = r_valid;
  assign bus.busy   = r_busy;
  assign bus.error  = r_error;

endmodule
